write_access_guard: RTL and testbench

WRITE_ACCESS_GUARD -- requirements
Module: write_access_guard

---
 rtl/guard_pkg.sv | 36 +++
 rtl/guard_alert_fifo.sv | 60 ++++++
 rtl/write_access_guard.sv | 174 +++++++++++++++++
 tb/tb_write_access_guard.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/guard_pkg.sv
// Shared definitions for the write access guard.
// Holds the default parameter values and the bit layout of an alert record.
// Record layout, MSB to LSB: {id, addr, data, locked}.
// Ports: none (package).
package guard_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ID_W        = 2;
  localparam int DEF_NUM_RULES   = 4;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_LOCK_THRESH = 3;

  // Width of the violation counter kept per requester ID.
  localparam int VIOL_CNT_W = 4;

  // Bit position of the locked flag inside an alert record.
  localparam int ALERT_LOCKED_LSB = 0;

  function automatic int alert_w(input int id_w, input int addr_w, input int data_w);
    return id_w + addr_w + data_w + 1;
  endfunction

  function automatic int alert_data_lsb();
    return ALERT_LOCKED_LSB + 1;
  endfunction

  function automatic int alert_addr_lsb(input int data_w);
    return alert_data_lsb() + data_w;
  endfunction

  function automatic int alert_id_lsb(input int addr_w, input int data_w);
    return alert_addr_lsb(data_w) + addr_w;
  endfunction

endpackage

// File: rtl/guard_alert_fifo.sv
// Alert FIFO for the write access guard.
// Circular buffer with an extra pointer bit separating full from empty.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and flagged on drop for one cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, push_data       write side
//   full, drop            full status, push-dropped strobe
//   pop_valid, pop_ready  read handshake (pop on valid && ready)
//   pop_data              head entry, stable while not popped
module guard_alert_fifo
  import guard_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             drop,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             pop;
  logic             push_ok;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_valid = !empty;
  assign pop       = pop_valid && pop_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign pop_data  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/write_access_guard.sv
// Write access guard.
// Checks each write attempt against a programmable rule table (owner ID plus
// inclusive address window), tracks violations per requester ID with lockout,
// and queues an alert record for each violation.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cfg_we/idx/en/id/base/limit       rule table write port
//   wr_valid/addr/data/id             write attempt
//   dec_valid, wr_allow, wr_block     registered decision (1 cycle latency)
//   alert_valid/ready, alert_*        alert FIFO head and pop handshake
//   alert_overflow                    sticky alert-dropped flag
//   lock_mask, clear_lock             per-ID lockout status and clear
module write_access_guard
  import guard_pkg::*;
#(
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int ID_W        = DEF_ID_W,
  parameter  int NUM_RULES   = DEF_NUM_RULES,
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter  int LOCK_THRESH = DEF_LOCK_THRESH,
  localparam int IDX_W       = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
  localparam int NUM_IDS     = 1 << ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [ID_W-1:0]    cfg_id,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W-1:0]  cfg_limit,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [ID_W-1:0]    wr_id,
  output logic               dec_valid,
  output logic               wr_allow,
  output logic               wr_block,
  output logic               alert_valid,
  input  logic               alert_ready,
  output logic [ID_W-1:0]    alert_id,
  output logic [ADDR_W-1:0]  alert_addr,
  output logic [DATA_W-1:0]  alert_data,
  output logic               alert_locked,
  output logic               alert_overflow,
  output logic [NUM_IDS-1:0] lock_mask,
  input  logic [NUM_IDS-1:0] clear_lock
);

  localparam int AW = alert_w(ID_W, ADDR_W, DATA_W);
  localparam logic [VIOL_CNT_W-1:0] THRESH = VIOL_CNT_W'(LOCK_THRESH);

  logic              rule_en    [NUM_RULES];
  logic [ID_W-1:0]   rule_id    [NUM_RULES];
  logic [ADDR_W-1:0] rule_base  [NUM_RULES];
  logic [ADDR_W-1:0] rule_limit [NUM_RULES];

  logic [VIOL_CNT_W-1:0] viol_cnt [NUM_IDS];
  logic [NUM_IDS-1:0]    lock_q;

  logic          hit_p0;
  logic          locked_p0;
  logic          allow_p0;
  logic          viol_p0;
  logic [AW-1:0] rec_p0;

  logic vld_p1;
  logic allow_p1;
  logic block_p1;

  logic          fifo_full;
  logic          fifo_drop;
  logic [AW-1:0] head;
  logic          ovf_q;

  // The table is written at the clock edge, so a same-cycle write attempt is
  // judged against the entries as they were before the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        rule_en[i]    <= 1'b0;
        rule_id[i]    <= '0;
        rule_base[i]  <= '0;
        rule_limit[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_RULES)) begin
      rule_en[cfg_idx]    <= cfg_en;
      rule_id[cfg_idx]    <= cfg_id;
      rule_base[cfg_idx]  <= cfg_base;
      rule_limit[cfg_idx] <= cfg_limit;
    end
  end

  // Stage p0: rule match and authorisation. A window with base > limit can
  // never satisfy both bounds, so it matches nothing without extra logic.
  always_comb begin
    hit_p0 = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (rule_en[i] && (rule_id[i] == wr_id) &&
          (wr_addr >= rule_base[i]) && (wr_addr <= rule_limit[i]))
        hit_p0 = 1'b1;
    end
  end

  assign locked_p0 = lock_q[wr_id];
  assign allow_p0  = hit_p0 && !locked_p0;
  assign viol_p0   = wr_valid && !allow_p0;
  assign rec_p0    = {wr_id, wr_addr, wr_data, locked_p0 && hit_p0};

  // Violation counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_IDS; k++) viol_cnt[k] <= '0;
      lock_q <= '0;
    end else begin
      for (int k = 0; k < NUM_IDS; k++) begin
        if (clear_lock[k]) begin
          viol_cnt[k] <= '0;
          lock_q[k]   <= 1'b0;
        end else if (viol_p0 && (wr_id == ID_W'(k)) && (viol_cnt[k] < THRESH)) begin
          viol_cnt[k] <= viol_cnt[k] + 1'b1;
          if (viol_cnt[k] + 1'b1 == THRESH) lock_q[k] <= 1'b1;
        end
      end
    end
  end

  // Stage p1: registered decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      allow_p1 <= 1'b0;
      block_p1 <= 1'b0;
    end else begin
      vld_p1   <= wr_valid;
      allow_p1 <= wr_valid && allow_p0;
      block_p1 <= viol_p0;
    end
  end

  // The FIFO captures on the same edge as the decision register, so the alert
  // becomes visible in the same cycle as dec_valid.
  guard_alert_fifo #(
    .WIDTH (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_alert_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (viol_p0),
    .push_data (rec_p0),
    .full      (fifo_full),
    .drop      (fifo_drop),
    .pop_valid (alert_valid),
    .pop_ready (alert_ready),
    .pop_data  (head)
  );

  always_ff @(posedge clk) begin
    if (rst)            ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
  end

  assign dec_valid      = vld_p1;
  assign wr_allow       = allow_p1;
  assign wr_block       = block_p1;
  assign lock_mask      = lock_q;
  assign alert_overflow = ovf_q;
  assign alert_locked   = head[ALERT_LOCKED_LSB];
  assign alert_data     = head[alert_data_lsb() +: DATA_W];
  assign alert_addr     = head[alert_addr_lsb(DATA_W) +: ADDR_W];
  assign alert_id       = head[alert_id_lsb(ADDR_W, DATA_W) +: ID_W];

endmodule

// File: tb/tb_write_access_guard.sv
module tb_write_access_guard;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic       cfg_en;
  logic [1:0] cfg_id;
  logic [7:0] cfg_base;
  logic [7:0] cfg_limit;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_id;
  logic       dec_valid;
  logic       wr_allow;
  logic       wr_block;
  logic       alert_valid;
  logic       alert_ready;
  logic [1:0] alert_id;
  logic [7:0] alert_addr;
  logic [7:0] alert_data;
  logic       alert_locked;
  logic       alert_overflow;
  logic [3:0] lock_mask;
  logic [3:0] clear_lock;

  int n_checks = 0;
  int n_fails  = 0;

  write_access_guard dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_id(cfg_id),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_id(wr_id),
    .dec_valid(dec_valid), .wr_allow(wr_allow), .wr_block(wr_block),
    .alert_valid(alert_valid), .alert_ready(alert_ready),
    .alert_id(alert_id), .alert_addr(alert_addr), .alert_data(alert_data),
    .alert_locked(alert_locked), .alert_overflow(alert_overflow),
    .lock_mask(lock_mask), .clear_lock(clear_lock)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are looked at 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; wr_valid = 1'b0; alert_ready = 1'b0; clear_lock = '0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic cfg_rule(input logic [1:0] idx, input logic en, input logic [1:0] id,
                          input logic [7:0] base, input logic [7:0] limit);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_id = id; cfg_base = base; cfg_limit = limit;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic set_wr(input logic [1:0] id, input logic [7:0] addr, input logic [7:0] data);
    wr_valid = 1'b1; wr_id = id; wr_addr = addr; wr_data = data;
  endtask

  task automatic pop_one();
    alert_ready = 1'b1;
    cycle();
    alert_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; alert_ready = 1'b0; clear_lock = '0;
    set_wr(2'd1, 8'h15, 8'h00);
    cycle(); cycle();
    n_checks++; if (dec_valid !== 1'b0) begin n_fails++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
    n_checks++; if ({wr_allow, wr_block} !== 2'b00) begin n_fails++; $display("FAIL reset_allow_block: got %b want 00", {wr_allow, wr_block}); end
    n_checks++; if (alert_valid !== 1'b0) begin n_fails++; $display("FAIL reset_alert_valid: got %b want 0", alert_valid); end
    n_checks++; if (lock_mask !== 4'b0000) begin n_fails++; $display("FAIL reset_lock_mask: got %b want 0000", lock_mask); end
    n_checks++; if (alert_overflow !== 1'b0) begin n_fails++; $display("FAIL reset_overflow: got %b want 0", alert_overflow); end
    wr_valid = 1'b0;
    rst = 1'b0;
    // Rules are all disabled after reset, so any write is blocked.
    set_wr(2'd0, 8'h00, 8'h00);
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b101) begin n_fails++; $display("FAIL reset_rules_disabled: got %b want 101", {dec_valid, wr_allow, wr_block}); end
  endtask

  task automatic test_allow();
    do_reset();
    cfg_rule(2'd0, 1'b1, 2'd1, 8'h10, 8'h1F);
    set_wr(2'd1, 8'h15, 8'h33);
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b110) begin n_fails++; $display("FAIL allow_decision: got %b want 110", {dec_valid, wr_allow, wr_block}); end
    n_checks++; if (alert_valid !== 1'b0) begin n_fails++; $display("FAIL allow_no_alert: got %b want 0", alert_valid); end
    cycle();
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b000) begin n_fails++; $display("FAIL allow_idle: got %b want 000", {dec_valid, wr_allow, wr_block}); end
  endtask

  task automatic test_block();
    do_reset();
    cfg_rule(2'd0, 1'b1, 2'd1, 8'h10, 8'h1F);
    set_wr(2'd1, 8'h20, 8'hAB);
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b101) begin n_fails++; $display("FAIL block_decision: got %b want 101", {dec_valid, wr_allow, wr_block}); end
    n_checks++; if (alert_valid !== 1'b1) begin n_fails++; $display("FAIL block_alert_valid: got %b want 1", alert_valid); end
    n_checks++; if ({alert_id, alert_addr, alert_data, alert_locked} !== {2'd1, 8'h20, 8'hAB, 1'b0})
      begin n_fails++; $display("FAIL block_alert_rec: got %h/%h/%h/%b want 1/20/ab/0", alert_id, alert_addr, alert_data, alert_locked); end
    pop_one();
    n_checks++; if (alert_valid !== 1'b0) begin n_fails++; $display("FAIL block_popped: got %b want 0", alert_valid); end
  endtask

  task automatic test_bounds();
    logic [7:0] addrs [6];
    logic [1:0] ids   [6];
    logic       exp   [6];
    do_reset();
    cfg_rule(2'd1, 1'b1, 2'd3, 8'h40, 8'h4F);
    cfg_rule(2'd2, 1'b1, 2'd0, 8'h80, 8'h70);
    addrs = '{8'h40, 8'h4F, 8'h3F, 8'h50, 8'h45, 8'h75};
    ids   = '{2'd3,  2'd3,  2'd3,  2'd3,  2'd2,  2'd0};
    exp   = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    for (int i = 0; i < 6; i++) begin
      set_wr(ids[i], addrs[i], 8'(i));
      cycle();
      n_checks++; if ({dec_valid, wr_allow, wr_block} !== {1'b1, exp[i], !exp[i]})
        begin n_fails++; $display("FAIL bounds_%0d: got %b want %b", i, {dec_valid, wr_allow, wr_block}, {1'b1, exp[i], !exp[i]}); end
    end
    wr_valid = 1'b0;
    cycle();
    n_checks++; if (lock_mask !== 4'b0000) begin n_fails++; $display("FAIL bounds_no_lock: got %b want 0000", lock_mask); end
    n_checks++; if (alert_overflow !== 1'b0) begin n_fails++; $display("FAIL bounds_no_overflow: got %b want 0", alert_overflow); end
  endtask

  task automatic test_lockout();
    do_reset();
    cfg_rule(2'd0, 1'b1, 2'd2, 8'h30, 8'h3F);
    for (int i = 0; i < 3; i++) begin
      set_wr(2'd2, 8'h50, 8'h00);
      cycle();
      n_checks++; if (lock_mask !== ((i == 2) ? 4'b0100 : 4'b0000))
        begin n_fails++; $display("FAIL lock_count_%0d: got %b want %b", i, lock_mask, (i == 2) ? 4'b0100 : 4'b0000); end
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({alert_valid, alert_locked} !== 2'b10) begin n_fails++; $display("FAIL lock_unlocked_alert_%0d: got %b want 10", i, {alert_valid, alert_locked}); end
      pop_one();
    end
    set_wr(2'd2, 8'h35, 8'h5A);
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({wr_allow, wr_block} !== 2'b01) begin n_fails++; $display("FAIL locked_block: got %b want 01", {wr_allow, wr_block}); end
    n_checks++; if ({alert_valid, alert_locked, alert_addr} !== {1'b1, 1'b1, 8'h35})
      begin n_fails++; $display("FAIL locked_alert: got %b/%b/%h want 1/1/35", alert_valid, alert_locked, alert_addr); end
    pop_one();
    clear_lock = 4'b0100;
    cycle();
    clear_lock = 4'b0000;
    n_checks++; if (lock_mask !== 4'b0000) begin n_fails++; $display("FAIL lock_cleared: got %b want 0000", lock_mask); end
    set_wr(2'd2, 8'h35, 8'h5A);
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b110) begin n_fails++; $display("FAIL after_clear_allow: got %b want 110", {dec_valid, wr_allow, wr_block}); end
    // Counter was zeroed too: two fresh violations must not relock.
    for (int i = 0; i < 2; i++) begin set_wr(2'd2, 8'h60, 8'h00); cycle(); end
    wr_valid = 1'b0;
    n_checks++; if (lock_mask !== 4'b0000) begin n_fails++; $display("FAIL counter_cleared: got %b want 0000", lock_mask); end
  endtask

  task automatic test_overflow();
    int popped;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_wr(2'd0, 8'(i + 1), 8'(8'hA1 + i));
      cycle();
    end
    wr_valid = 1'b0;
    n_checks++; if (alert_overflow !== 1'b1) begin n_fails++; $display("FAIL overflow_set: got %b want 1", alert_overflow); end
    cycle();
    n_checks++; if ({alert_valid, alert_addr, alert_data} !== {1'b1, 8'h01, 8'hA1})
      begin n_fails++; $display("FAIL head_stable: got %b/%h/%h want 1/01/a1", alert_valid, alert_addr, alert_data); end
    popped = 0;
    for (int i = 0; i < 8 && alert_valid === 1'b1; i++) begin
      n_checks++; if ({alert_addr, alert_data} !== {8'(i + 1), 8'(8'hA1 + i)})
        begin n_fails++; $display("FAIL pop_order_%0d: got %h/%h want %h/%h", i, alert_addr, alert_data, 8'(i + 1), 8'(8'hA1 + i)); end
      pop_one();
      popped++;
    end
    n_checks++; if (popped !== 4) begin n_fails++; $display("FAIL overflow_held: got %0d want 4", popped); end
    n_checks++; if (alert_overflow !== 1'b1) begin n_fails++; $display("FAIL overflow_sticky: got %b want 1", alert_overflow); end
  endtask

  task automatic test_full_push_pop();
    int popped;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_wr(2'd3, 8'(8'h61 + i), 8'h00);
      cycle();
    end
    set_wr(2'd3, 8'h65, 8'h00);
    alert_ready = 1'b1;
    cycle();
    wr_valid = 1'b0;
    alert_ready = 1'b0;
    n_checks++; if (alert_overflow !== 1'b0) begin n_fails++; $display("FAIL pushpop_no_overflow: got %b want 0", alert_overflow); end
    popped = 0;
    for (int i = 0; i < 8 && alert_valid === 1'b1; i++) begin
      n_checks++; if (alert_addr !== 8'(8'h62 + i)) begin n_fails++; $display("FAIL pushpop_order_%0d: got %h want %h", i, alert_addr, 8'(8'h62 + i)); end
      pop_one();
      popped++;
    end
    n_checks++; if (popped !== 4) begin n_fails++; $display("FAIL pushpop_occupancy: got %0d want 4", popped); end
  endtask

  task automatic test_cfg_same_cycle();
    do_reset();
    cfg_rule(2'd0, 1'b1, 2'd1, 8'h10, 8'h1F);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b0; cfg_id = 2'd1; cfg_base = 8'h10; cfg_limit = 8'h1F;
    set_wr(2'd1, 8'h12, 8'h77);
    cycle();
    cfg_we = 1'b0;
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b110) begin n_fails++; $display("FAIL cfg_same_cycle_allow: got %b want 110", {dec_valid, wr_allow, wr_block}); end
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({dec_valid, wr_allow, wr_block} !== 3'b101) begin n_fails++; $display("FAIL cfg_next_block: got %b want 101", {dec_valid, wr_allow, wr_block}); end
  endtask

  task automatic test_midreset();
    do_reset();
    set_wr(2'd1, 8'h99, 8'h00);
    cycle();
    n_checks++; if (alert_valid !== 1'b1) begin n_fails++; $display("FAIL midrst_alert_before: got %b want 1", alert_valid); end
    rst = 1'b1;
    cycle();
    n_checks++; if ({dec_valid, wr_block, alert_valid} !== 3'b000) begin n_fails++; $display("FAIL midrst_discard: got %b want 000", {dec_valid, wr_block, alert_valid}); end
    rst = 1'b0;
    wr_valid = 1'b0;
    cycle();
    n_checks++; if (dec_valid !== 1'b0) begin n_fails++; $display("FAIL midrst_idle: got %b want 0", dec_valid); end
    set_wr(2'd1, 8'h99, 8'h00);
    cycle();
    wr_valid = 1'b0;
    n_checks++; if ({dec_valid, wr_block, alert_valid} !== 3'b111) begin n_fails++; $display("FAIL midrst_first_dec: got %b want 111", {dec_valid, wr_block, alert_valid}); end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_id = '0; cfg_base = '0; cfg_limit = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_id = '0;
    alert_ready = 1'b0; clear_lock = '0; rst = 1'b1;
    test_reset();
    test_allow();
    test_block();
    test_bounds();
    test_lockout();
    test_overflow();
    test_full_push_pop();
    test_cfg_same_cycle();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
